// File: rtl/timer_unit_pkg.sv
// -----------------------------------------------------------------------------
// timer_unit_pkg
// Shared definitions for the timer unit: FSM state encoding, register indices
// (addr[3:2]), CTRL bit positions and MODE encodings.
// -----------------------------------------------------------------------------
package timer_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Register indices as decoded from addr[3:2]
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESET   = 2'd1;
  localparam logic [1:0] REG_COUNT    = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  // CTRL layout
  localparam int CTRL_W       = 4;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // MODE encodings; 1x is treated like one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int PRESCALE_W = 8;

  function automatic logic is_auto_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_unit_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
// Tick divider: while enable is high, tick asserts once every prescale+1
// cycles. clear restarts the division (used on LOAD).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clear           restart the divider
//   enable          divider advances only while high
//   prescale[7:0]   division ratio minus one
//   tick            combinational tick output
// -----------------------------------------------------------------------------
module timer_prescaler
  import timer_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] div_reg;

  // >= rather than == so that lowering prescale mid-count below the current
  // divider value yields a prompt tick instead of a 256-cycle wrap.
  assign tick = enable && (div_reg >= prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= '0;
    end else if (clear) begin
      div_reg <= '0;
    end else if (enable) begin
      div_reg <= tick ? '0 : div_reg + 1'b1;
    end
  end

endmodule

// File: rtl/timer_unit.sv
// -----------------------------------------------------------------------------
// timer_unit
// Memory-mapped down-counting timer with interrupt. Registers (addr[3:2]):
//   0 CTRL     [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload), [3] IM
//   1 PRESET   reload value
//   2 COUNT    current count (read-only)
//   3 PRESCALE 8-bit tick divider when TIMER_UNIT_PRESCALE_EN is defined,
//              otherwise reads 0 and ignores writes
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   addr         byte address (only [3:2] decoded)
//   sel, we      a write happens on cycles with sel & we
//   wdata        write data
//   rdata        combinational read data for addr[3:2]
//   irq          PENDING & IM
// Optional feature macro: TIMER_UNIT_PRESCALE_EN
// -----------------------------------------------------------------------------
module timer_unit
  import timer_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t             state_reg;
  logic [CTRL_W-1:0]  ctrl_reg;
  logic [31:0]        preset_reg;
  logic [31:0]        count_reg;
  logic               pending_reg;
  logic               tick;

  logic [1:0] reg_idx;
  logic       ctrl_wr;
  logic       preset_wr;
  logic       counting;
  logic       expire;
  logic       unused_addr_bits;

  assign reg_idx   = addr[3:2];
  assign ctrl_wr   = sel && we && (reg_idx == REG_CTRL);
  assign preset_wr = sel && we && (reg_idx == REG_PRESET);

  // Counting is live only while enabled and not yet at zero; expiry is the
  // CNT-state edge that moves to INT and raises PENDING.
  assign counting = (state_reg == ST_CNT) && ctrl_reg[CTRL_EN] && (count_reg != 32'd0);
  assign expire   = (state_reg == ST_CNT) && ctrl_reg[CTRL_EN] && (count_reg == 32'd0);

  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

`ifdef TIMER_UNIT_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_reg;
  logic                  prescale_wr;

  assign prescale_wr = sel && we && (reg_idx == REG_PRESCALE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_reg <= '0;
    end else if (prescale_wr) begin
      prescale_reg <= wdata[PRESCALE_W-1:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_reg == ST_LOAD),
    .enable   (counting),
    .prescale (prescale_reg),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // Control FSM plus register file. The CTRL write is placed after the FSM
  // so that a bus write beats the FSM's own EN clear in the same cycle.
  // PENDING set on expiry beats a simultaneous CTRL-write clear so that an
  // interrupt is never silently lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      ctrl_reg    <= '0;
      preset_reg  <= RESET_PRESET;
      count_reg   <= '0;
      pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ctrl_reg[CTRL_EN]) begin
            state_reg <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count_reg <= preset_reg;
          state_reg <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl_reg[CTRL_EN]) begin
            state_reg <= ST_IDLE;
          end else if (count_reg == 32'd0) begin
            state_reg   <= ST_INT;
            pending_reg <= 1'b1;
          end else if (tick) begin
            count_reg <= count_reg - 32'd1;
          end
        end
        ST_INT: begin
          if (is_auto_reload(ctrl_reg[CTRL_MODE_HI:CTRL_MODE_LO])) begin
            state_reg   <= ST_LOAD;
            pending_reg <= 1'b0;
          end else begin
            ctrl_reg[CTRL_EN] <= 1'b0;
            state_reg         <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (ctrl_wr) begin
        ctrl_reg <= wdata[CTRL_W-1:0];
        if (!expire) begin
          pending_reg <= 1'b0;
        end
      end

      if (preset_wr) begin
        preset_reg <= wdata;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (reg_idx)
      REG_CTRL:     rdata = {{(32-CTRL_W){1'b0}}, ctrl_reg};
      REG_PRESET:   rdata = preset_reg;
      REG_COUNT:    rdata = count_reg;
`ifdef TIMER_UNIT_PRESCALE_EN
      REG_PRESCALE: rdata = {{(32-PRESCALE_W){1'b0}}, prescale_reg};
`else
      REG_PRESCALE: rdata = 32'h0;
`endif
      default:      rdata = 32'h0;
    endcase
  end

  assign irq = pending_reg & ctrl_reg[CTRL_IM];

endmodule

// File: tb/tb_timer_unit.sv
// -----------------------------------------------------------------------------
// tb_timer_unit
// Directed bench for timer_unit. A behavioural model, stepped on the same
// clock, predicts rdata and irq; a negedge process compares them every cycle.
// Hand-computed literal expectations pin the key timelines.
// -----------------------------------------------------------------------------
module tb_timer_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        sel;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks = 0;
  int passes = 0;

  timer_unit #(.RESET_PRESET(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .sel   (sel),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for enable, 1 reload pending, 2 counting, 3 expired
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [7:0]  prescale;
    logic [7:0]  div;
    logic        pending;
    int          phase;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.ctrl = 4'h0; r.preset = 32'h0; r.count = 32'h0;
    r.prescale = 8'h0; r.div = 8'h0; r.pending = 1'b0; r.phase = 0;
    return r;
  endfunction

  function automatic model_t model_next(input model_t s, input logic s_sel, input logic s_we,
                                        input logic [31:0] s_addr, input logic [31:0] s_wdata);
    model_t n;
    logic fired;
    logic do_tick;
    n = s;
    fired = 1'b0;
    do_tick = 1'b1;
    if (s.phase == 0) begin
      if (s.ctrl[0]) n.phase = 1;
    end else if (s.phase == 1) begin
      n.count = s.preset;
      n.div = 8'h0;
      n.phase = 2;
    end else if (s.phase == 2) begin
      if (!s.ctrl[0]) n.phase = 0;
      else if (s.count == 0) begin
        n.phase = 3; n.pending = 1'b1; fired = 1'b1;
      end else begin
`ifdef TIMER_UNIT_PRESCALE_EN
        do_tick = (s.div >= s.prescale);
        n.div = do_tick ? 8'h0 : s.div + 8'h1;
`endif
        if (do_tick) n.count = s.count - 1;
      end
    end else begin
      if (s.ctrl[2:1] == 2'b01) begin
        n.phase = 1; n.pending = 1'b0;
      end else begin
        n.ctrl[0] = 1'b0; n.phase = 0;
      end
    end
    if (s_sel && s_we) begin
      case (s_addr[3:2])
        2'd0: begin n.ctrl = s_wdata[3:0]; if (!fired) n.pending = 1'b0; end
        2'd1: n.preset = s_wdata;
`ifdef TIMER_UNIT_PRESCALE_EN
        2'd3: n.prescale = s_wdata[7:0];
`endif
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] model_read(input model_t s, input logic [31:0] a);
    case (a[3:2])
      2'd0: return {28'h0, s.ctrl};
      2'd1: return s.preset;
      2'd2: return s.count;
`ifdef TIMER_UNIT_PRESCALE_EN
      default: return {24'h0, s.prescale};
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= model_reset();
    else m <= model_next(m, sel, we, addr, wdata);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    check("model_rdata", rdata, model_read(m, addr));
    check("model_irq", 32'(irq), 32'(m.pending & m.ctrl[3]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = {28'h0, idx, 2'b00}; wdata = d;
    @(posedge clk); #1;
    $display("write idx=%0d data=%h", idx, d);
    sel = 1'b0; we = 1'b0; addr = 32'h8;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string name, input logic [1:0] idx, input logic [31:0] exp);
    addr = {28'h0, idx, 2'b00};
    #1;
    check(name, rdata, exp);
    $display("read idx=%0d data=%h expect=%h", idx, rdata, exp);
    addr = 32'h8;
  endtask

  logic irq_trace [40];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    int prev;
    bit found;
    sel = 0; we = 0; addr = 32'h8; wdata = 0; reset = 0;
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    rd_check("rst_ctrl", 2'd0, 32'h0);
    rd_check("rst_preset", 2'd1, 32'h0);
    rd_check("rst_count", 2'd2, 32'h0);
    rd_check("rst_prescale", 2'd3, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset = 0;
    cyc(2);

    // One-shot with interrupt, PRESET=5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);                 // edge t0
    cyc(2); rd_check("oneshot_t2_count", 2'd2, 32'd5);
    cyc(5); rd_check("oneshot_t7_count", 2'd2, 32'd0);
    check("oneshot_t7_irq", 32'(irq), 32'h0);
    cyc(1); check("oneshot_t8_irq", 32'(irq), 32'h1);
    cyc(1); rd_check("oneshot_t9_ctrl", 2'd0, 32'h8);
    check("oneshot_t9_irq", 32'(irq), 32'h1);
    cyc(3); check("oneshot_irq_held", 32'(irq), 32'h1);
    wr(2'd0, 32'h0);
    check("oneshot_irq_cleared", 32'(irq), 32'h0);
    cyc(2);

    // Auto-reload, PRESET=3: one-cycle pulse every 6 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      irq_trace[i] = irq;
    end
    pulses = 0;
    prev = -1;
    for (int i = 0; i < 40; i++) begin
      if (irq_trace[i]) begin
        pulses++;
        if (prev >= 0) check("reload_gap", 32'(i - prev), 32'd6);
        if (i < 39) check("reload_width", 32'(irq_trace[i+1]), 32'h0);
        prev = i;
      end
    end
    check("reload_first_pulse", 32'(irq_trace[5]), 32'h1);
    check("reload_pulse_count", 32'(pulses), 32'd6);
    wr(2'd0, 32'h0);
    cyc(8);

    // Masked expiry, then CTRL write clears pending
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    cyc(8);
    check("masked_irq", 32'(irq), 32'h0);
    rd_check("masked_ctrl_en_cleared", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    check("masked_unmask_irq", 32'(irq), 32'h0);
    rd_check("masked_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h0);
    cyc(2);

    // PRESET rewrite during count takes effect at next reload
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h3);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc(1);
      if (rdata == 32'd4) found = 1;
    end
    check("rewrite_reached_4", 32'(found), 32'h1);
    wr(2'd1, 32'd2);
    rd_check("rewrite_c3", 2'd2, 32'd3);
    cyc(1); rd_check("rewrite_c2", 2'd2, 32'd2);
    cyc(1); rd_check("rewrite_c1", 2'd2, 32'd1);
    cyc(1); rd_check("rewrite_c0", 2'd2, 32'd0);
    cyc(3); rd_check("rewrite_reload", 2'd2, 32'd2);
    wr(2'd0, 32'h0);
    cyc(6);

    // PRESET=0 expires on the first CNT cycle
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    cyc(2); check("zero_t2_irq", 32'(irq), 32'h0);
    cyc(1); check("zero_t3_irq", 32'(irq), 32'h1);
    wr(2'd0, 32'h0);
    cyc(2);

    // Register bit masking and read-only / optional registers
    wr(2'd0, 32'hFFFF_FFF8);
    rd_check("ctrl_upper_ignored", 2'd0, 32'h8);
    wr(2'd2, 32'h1234);
    rd_check("count_write_ignored", 2'd2, 32'h0);
    wr(2'd3, 32'd3);
`ifdef TIMER_UNIT_PRESCALE_EN
    rd_check("prescale_readback", 2'd3, 32'd3);
    wr(2'd3, 32'd0);
`else
    rd_check("prescale_absent", 2'd3, 32'd0);
`endif
    wr(2'd0, 32'h0);
    cyc(2);

    // Reset asserted mid-count aborts immediately
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    cyc(10);
    rd_check("midrst_pre_count", 2'd2, 32'd92);
    #2 reset = 1;
    #1;
    rd_check("midrst_count", 2'd2, 32'h0);
    rd_check("midrst_preset", 2'd1, 32'h0);
    rd_check("midrst_ctrl", 2'd0, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    #1 reset = 0;
    cyc(5);
    rd_check("midrst_idle_count", 2'd2, 32'h0);
    check("midrst_idle_irq", 32'(irq), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
